// File: rtl/timer_arb_pkg.sv
// ============================================================================
// timer_arb_pkg : shared types and constants for the timer arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic        REQ       = 1'b1;
  localparam logic        ACK       = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int          TMO_W     = 8;

endpackage

`default_nettype wire

// File: rtl/timer_arb_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin pick, search starts after last winner
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import timer_arb_pkg::*;
#(
  parameter int N_MST = 4,
  parameter int IDXW  = (N_MST > 1) ? $clog2(N_MST) : 1
) (
  input  logic [N_MST-1:0] req_i,
  input  logic [IDXW-1:0]  last_i,
  output logic [IDXW-1:0]  grant_o,
  output logic             valid_o
);

  logic [IDXW-1:0] cand;

  // Offsets 1..N_MST visit every master once, the previous winner last.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_MST; k++) begin
      cand = IDXW'((int'(last_i) + k) % N_MST);
      if (!valid_o && (req_i[cand] == REQ)) begin
        valid_o = 1'b1;
        grant_o = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_arb.sv
// ============================================================================
// timer_arb : round-robin sequencer sharing one timer slave among N masters
// Revision 1.0
// ============================================================================
`default_nettype none

module timer_arb
  import timer_arb_pkg::*;
#(
  parameter int N_MST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_MST-1:0]    m_req_i,
  input  logic [N_MST-1:0]    m_we_i,
  input  logic [32*N_MST-1:0] m_addr_i,
  input  logic [32*N_MST-1:0] m_data_i,
  output logic [31:0]         m_data_o,
  output logic [N_MST-1:0]    m_ack_o,
  output logic [N_MST-1:0]    m_err_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [31:0]         s_addr_o,
  output logic [31:0]         s_data_o,
  input  logic [31:0]         s_data_i,
  input  logic                s_ack_i
);

  localparam int               IDXW     = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [IDXW-1:0]  LAST_RST = IDXW'(N_MST - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  last_q, last_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [IDXW-1:0]  pick_idx;
  logic             pick_vld;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_data;
  logic [N_MST-1:0] idx_onehot;

  rr_pick #(
    .N_MST (N_MST),
    .IDXW  (IDXW)
  ) u_rr_pick (
    .req_i   (m_req_i),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = ZERO_WORD;
    sel_data = ZERO_WORD;
    for (int i = 0; i < N_MST; i++) begin
      if (pick_idx == IDXW'(i)) begin
        sel_we   = m_we_i[i];
        sel_addr = m_addr_i[32*i +: 32];
        sel_data = m_data_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d     = pick_idx;
          we_d      = sel_we;
          addr_d    = sel_addr;
          data_d    = sel_data;
          tmo_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i == ACK) begin
          rd_data_d = s_data_i;
          err_d     = 1'b0;
          state_d   = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rd_data_d = ZERO_WORD;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= LAST_RST;
      we_q      <= 1'b0;
      addr_q    <= ZERO_WORD;
      data_q    <= ZERO_WORD;
      rd_data_q <= ZERO_WORD;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Every output decodes from flops only; nothing from m_*_i reaches them.
  assign idx_onehot = {{(N_MST-1){1'b0}}, 1'b1} << idx_q;
  assign s_req_o    = (state_q == BUSY);
  assign s_we_o     = we_q;
  assign s_addr_o   = addr_q;
  assign s_data_o   = data_q;
  assign m_ack_o    = ((state_q == RESP) && !err_q) ? idx_onehot : '0;
  assign m_err_o    = ((state_q == RESP) &&  err_q) ? idx_onehot : '0;
  assign m_data_o   = (state_q == RESP) ? rd_data_q : ZERO_WORD;

endmodule

`default_nettype wire

// File: tb/tb_timer_arb.sv
// ============================================================================
// tb_timer_arb : directed scoreboard bench for timer_arb with a slave model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_timer_arb;

  localparam int N   = 4;
  localparam int TMO = 16;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        err;
    logic        b2b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  m_req_i;
  logic [N-1:0]  m_we_i   = '0;
  logic [32*N-1:0] m_addr_i = '0;
  logic [32*N-1:0] m_data_i = '0;
  logic [31:0]   m_data_o;
  logic [N-1:0]  m_ack_o;
  logic [N-1:0]  m_err_o;
  logic          s_req_o;
  logic          s_we_o;
  logic [31:0]   s_addr_o;
  logic [31:0]   s_data_o;
  logic [31:0]   s_data_i = '0;
  logic          s_ack_i  = 1'b0;

  int   tests = 0;
  int   fails = 0;
  int   issued [N];
  int   served [N];
  logic [N-1:0] dropped = '0;
  exp_t exp_q [$];

  int   cyc = 0;
  int   busy_cnt = 0;
  int   last_busy = 0;
  int   last_pulse_cyc = 0;
  logic prev_req = 1'b0;
  logic prev_pulse = 1'b0;
  logic [N-1:0] pulse;
  logic [N-1:0] oh;
  exp_t e;

  timer_arb #(.N_MST(N), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req_i  (m_req_i),
    .m_we_i   (m_we_i),
    .m_addr_i (m_addr_i),
    .m_data_i (m_data_i),
    .m_data_o (m_data_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_req_o  (s_req_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i)
  );

  always #5 clk = ~clk;

  // A master's level stays high while it has unserved transactions.
  always_comb begin
    m_req_i = '0;
    for (int i = 0; i < N; i++)
      m_req_i[i] = (issued[i] != served[i]) && !dropped[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Slave model and response scoreboard, both sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy_cnt   = 0;
      s_ack_i    = 1'b0;
      prev_req   = 1'b0;
      prev_pulse = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) served[i] = issued[i];
    end else begin
      pulse = m_ack_o | m_err_o;
      if (!s_req_o && busy_cnt != 0) begin
        last_busy = busy_cnt;
        busy_cnt  = 0;
      end
      if (pulse != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'(pulse), 32'h0);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e.idx;
          chk("ack_vec",   32'(m_ack_o), e.err ? 32'h0 : 32'(oh));
          chk("err_vec",   32'(m_err_o), e.err ? 32'(oh) : 32'h0);
          chk("rd_data",   m_data_o, e.err ? 32'h0 : e.rdata);
          chk("busy_len",  32'(last_busy), e.err ? 32'(TMO) : 32'(e.delay + 1));
          chk("resp_after_busy", 32'(prev_req), 32'h1);
          chk("pulse_width", 32'(prev_pulse), 32'h0);
          if (e.b2b) chk("b2b_spacing", 32'(cyc - last_pulse_cyc), 32'd3);
        end
        for (int i = 0; i < N; i++)
          if (pulse[i]) served[i]++;
        last_pulse_cyc = cyc;
      end else begin
        chk("data_idle_zero", m_data_o, 32'h0);
      end
      if (s_req_o) begin
        if (exp_q.size() != 0) begin
          chk("s_addr", s_addr_o, exp_q[0].addr);
          chk("s_we",   32'(s_we_o), 32'(exp_q[0].we));
          chk("s_data", s_data_o, exp_q[0].wdata);
          s_ack_i  = (busy_cnt == exp_q[0].delay);
          s_data_i = exp_q[0].rdata;
        end else begin
          s_ack_i = 1'b0;
        end
        busy_cnt++;
      end else begin
        s_ack_i = 1'b0;
      end
      prev_req   = s_req_o;
      prev_pulse = (pulse != '0);
    end
  end

  task automatic issue(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rdata, input int delay, input logic err, input logic b2b);
    exp_t x;
    x.idx = i; x.we = we; x.addr = a; x.wdata = d; x.rdata = rdata;
    x.delay = delay; x.err = err; x.b2b = b2b;
    m_we_i[i] = we;
    m_addr_i[32*i +: 32] = a;
    m_data_i[32*i +: 32] = d;
    issued[i]++;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_req_i != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'h1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_sreq(input string tag, input int budget);
    int n = 0;
    while (!s_req_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      issued[i] = 0;
      served[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_req",  32'(s_req_o), 32'h0);
    chk("rst_s_we",   32'(s_we_o), 32'h0);
    chk("rst_s_addr", s_addr_o, 32'h0);
    chk("rst_s_data", s_data_o, 32'h0);
    chk("rst_ack",    32'(m_ack_o), 32'h0);
    chk("rst_err",    32'(m_err_o), 32'h0);
    chk("rst_mdata",  m_data_o, 32'h0);
    rst = 1'b0;

    // Round robin from reset: all four hold writes, master 0 renews once.
    @(negedge clk); #1;
    issue(0, 1'b1, 32'h0000_0010, 32'hAAAA_0000, 32'h0000_00A0, 0, 1'b0, 1'b0);
    issue(1, 1'b1, 32'h0000_0014, 32'hBBBB_0001, 32'h0000_00A1, 0, 1'b0, 1'b1);
    issue(2, 1'b1, 32'h0000_0018, 32'hCCCC_0002, 32'h0000_00A2, 0, 1'b0, 1'b1);
    issue(3, 1'b1, 32'h0000_001C, 32'hDDDD_0003, 32'h0000_00A3, 0, 1'b0, 1'b1);
    issue(0, 1'b1, 32'h0000_0010, 32'hAAAA_0000, 32'h0000_00A0, 0, 1'b0, 1'b1);
    wait_done("rr_done", 100);

    // Single read with same-cycle ack.
    issue(2, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_1234, 0, 1'b0, 1'b0);
    wait_done("single_done", 50);

    // Timeout, then a normal transaction from the same master.
    issue(1, 1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 255, 1'b1, 1'b0);
    wait_done("tmo_done", 100);
    issue(1, 1'b0, 32'h0000_0024, 32'h0, 32'h0000_5678, 0, 1'b0, 1'b0);
    wait_done("post_tmo_done", 50);

    // Master inputs change while BUSY; slave acks after 5 extra cycles.
    issue(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0777, 5, 1'b0, 1'b0);
    wait_sreq("iso_sreq", 20);
    @(negedge clk); #1;
    m_addr_i[31:0] = 32'h0000_0004;
    m_data_i[31:0] = 32'h1111_2222;
    m_we_i[0]      = 1'b1;
    wait_done("iso_done", 50);
    m_we_i[0] = 1'b0;

    // Asynchronous reset in the middle of a transaction.
    issue(0, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_0999, 255, 1'b0, 1'b0);
    wait_sreq("arst_sreq", 20);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_s_req", 32'(s_req_o), 32'h0);
    chk("arst_ack",   32'(m_ack_o), 32'h0);
    chk("arst_err",   32'(m_err_o), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    issue(0, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0100, 0, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h0000_0048, 32'h0, 32'h0000_0102, 0, 1'b0, 1'b1);
    wait_done("arst_after_done", 50);

    // Master 3 drops its request mid-BUSY; the pulse must still come.
    issue(3, 1'b0, 32'h0000_0050, 32'h0, 32'h0000_0303, 3, 1'b0, 1'b0);
    wait_sreq("drop_sreq", 20);
    @(negedge clk); #1;
    dropped[3] = 1'b1;
    wait_done("drop_done", 50);
    dropped[3] = 1'b0;

    // With last at 3, master 0 must beat master 3.
    issue(0, 1'b0, 32'h0000_0060, 32'h0, 32'h0000_0600, 0, 1'b0, 1'b0);
    issue(3, 1'b0, 32'h0000_006C, 32'h0, 32'h0000_0603, 0, 1'b0, 1'b1);
    wait_done("last3_done", 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
